// File: rtl/seg7_frame_decoder_if.sv
// rtl/seg7_frame_decoder_if.sv - segment-bus sample input and decoded frame outputs
interface seg7_frame_decoder_if #(
    parameter int PERIOD_WIDTH = 24
);
    logic                    ena;
    logic [6:0]              seg_in;
    logic                    frame_valid;
    logic [6:0]              frame_pattern;
    logic [3:0]              digit;
    logic                    digit_ok;
    logic [7:0]              frame_count;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;
    logic                    overflow;

    modport master (
        output ena, seg_in,
        input  frame_valid, frame_pattern, digit, digit_ok,
        input  frame_count, period, period_valid, overflow
    );

    modport slave (
        input  ena, seg_in,
        output frame_valid, frame_pattern, digit, digit_ok,
        output frame_count, period, period_valid, overflow
    );
endinterface

// File: rtl/seg7_frame_decoder.sv
// rtl/seg7_frame_decoder.sv - debounces a 7-segment bus, decodes hex glyphs, times frames
module seg7_frame_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int PERIOD_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_frame_decoder_if.slave  bus
);
    localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [PERIOD_WIDTH-1:0] PMAX = {PERIOD_WIDTH{1'b1}};

    logic [6:0]              s1, s2, cand;
    logic [SW-1:0]           stab;
    logic [PERIOD_WIDTH-1:0] pcnt;
    logic                    seen;
    logic                    accept;
    logic [3:0]              dec_digit;
    logic                    dec_ok;

    // The synchronizer runs regardless of ena so re-enabling sees a settled bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 7'h00;
            s2 <= 7'h00;
        end else begin
            s1 <= bus.seg_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= 7'h00;
            stab <= '0;
        end else if (bus.ena) begin
            if (s2 != cand) begin
                cand <= s2;
                stab <= '0;
            end else if (stab != STAB_MAX) begin
                stab <= stab + SW'(1);
            end
        end
    end

    assign accept = bus.ena && (s2 == cand) && (stab == STAB_MAX) &&
                    (cand != bus.frame_pattern);

    always_comb begin
        dec_digit = 4'h0;
        dec_ok    = 1'b1;
        case (cand)
            7'h3F: dec_digit = 4'h0;
            7'h06: dec_digit = 4'h1;
            7'h5B: dec_digit = 4'h2;
            7'h4F: dec_digit = 4'h3;
            7'h66: dec_digit = 4'h4;
            7'h6D: dec_digit = 4'h5;
            7'h7D: dec_digit = 4'h6;
            7'h07: dec_digit = 4'h7;
            7'h7F: dec_digit = 4'h8;
            7'h6F: dec_digit = 4'h9;
            7'h77: dec_digit = 4'hA;
            7'h7C: dec_digit = 4'hB;
            7'h39: dec_digit = 4'hC;
            7'h5E: dec_digit = 4'hD;
            7'h79: dec_digit = 4'hE;
            7'h71: dec_digit = 4'hF;
            default: begin
                dec_digit = 4'h0;
                dec_ok    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.frame_valid   <= 1'b0;
            bus.frame_pattern <= 7'h00;
            bus.digit         <= 4'h0;
            bus.digit_ok      <= 1'b0;
            bus.frame_count   <= 8'h00;
            bus.period        <= '0;
            bus.period_valid  <= 1'b0;
            bus.overflow      <= 1'b0;
            pcnt              <= '0;
            seen              <= 1'b0;
        end else if (bus.ena) begin
            bus.frame_valid <= accept;
            if (accept) begin
                bus.frame_pattern <= cand;
                bus.digit         <= dec_digit;
                bus.digit_ok      <= dec_ok;
                bus.frame_count   <= bus.frame_count + 8'd1;
                bus.period        <= pcnt;
                bus.period_valid  <= bus.period_valid | seen;
                seen              <= 1'b1;
                pcnt              <= PERIOD_WIDTH'(1);
            end else begin
                if (pcnt != PMAX)
                    pcnt <= pcnt + PERIOD_WIDTH'(1);
                // Flag as soon as the counter lands on its ceiling, not one cycle later.
                if (pcnt >= PMAX - PERIOD_WIDTH'(1))
                    bus.overflow <= 1'b1;
            end
        end else begin
            bus.frame_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb/tb_seg7_frame_decoder.sv - scoreboard bench for seg7_frame_decoder
module tb_seg7_frame_decoder;
    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_frame_decoder_if #(.PERIOD_WIDTH(24)) bus1 ();
    seg7_frame_decoder_if #(.PERIOD_WIDTH(8))  bus2 ();

    seg7_frame_decoder #(.STABLE_CYCLES(16), .PERIOD_WIDTH(24)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    seg7_frame_decoder #(.STABLE_CYCLES(16), .PERIOD_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst2_n), .bus(bus2));

    typedef struct {
        logic [6:0]  pat;
        logic [3:0]  dig;
        logic        ok;
        logic [7:0]  cnt;
        logic [23:0] per;
        bit          chk_per;
        logic        pv;
        int          at;
    } exp_t;

    exp_t sbq[$];
    int   exp_cnt = 0;
    int   exp_acc = 0;
    int   last_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [6:0] pat, input logic [3:0] dig, input logic ok,
                            input int at, input int frozen, input bit chk_per);
        exp_t e;
        exp_cnt++;
        e.pat = pat; e.dig = dig; e.ok = ok;
        e.cnt = exp_cnt[7:0];
        e.per = 24'(at - last_acc - frozen);
        e.chk_per = chk_per;
        e.pv = (exp_acc > 0);
        e.at = at;
        exp_acc++;
        last_acc = at;
        sbq.push_back(e);
    endtask

    // Monitor: pops one expectation per frame_valid pulse; a late or surplus pulse is a failure.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (bus1.frame_valid) begin
                if (sbq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_frame actual=%0h required=none (cycle %0d)",
                             bus1.frame_pattern, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("fv_cycle", 32'(cyc), 32'(e.at));
                    check("pattern", 32'(bus1.frame_pattern), 32'(e.pat));
                    check("digit", 32'(bus1.digit), 32'(e.dig));
                    check("digit_ok", 32'(bus1.digit_ok), 32'(e.ok));
                    check("frame_count", 32'(bus1.frame_count), 32'(e.cnt));
                    check("period_valid", 32'(bus1.period_valid), 32'(e.pv));
                    if (e.chk_per) check("period", 32'(bus1.period), 32'(e.per));
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].at) begin
                checks++; failures++;
                $display("FAIL missing_frame actual=none required=%0h (cycle %0d)", sbq[0].pat, cyc);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic check_idle1(input string tag);
        check({tag, "_fp"},   32'(bus1.frame_pattern), 32'h0);
        check({tag, "_fv"},   32'(bus1.frame_valid), 32'h0);
        check({tag, "_dig"},  32'(bus1.digit), 32'h0);
        check({tag, "_ok"},   32'(bus1.digit_ok), 32'h0);
        check({tag, "_cnt"},  32'(bus1.frame_count), 32'h0);
        check({tag, "_per"},  32'(bus1.period), 32'h0);
        check({tag, "_pv"},   32'(bus1.period_valid), 32'h0);
        check({tag, "_ovf"},  32'(bus1.overflow), 32'h0);
    endtask

    task automatic wait_fv2(input string name, input int start);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus2.frame_valid) got = 1;
        end
        check({name, "_seen"}, 32'(got), 32'h1);
        if (got) check({name, "_cycle"}, 32'(cyc), 32'(start + 19));
    endtask

    initial begin
        int start;
        rst_n = 1'b0; rst2_n = 1'b0;
        bus1.ena = 1'b1; bus1.seg_in = 7'h00;
        bus2.ena = 1'b1; bus2.seg_in = 7'h00;
        repeat (3) @(negedge clk);
        check_idle1("reset");
        rst_n = 1'b1;

        repeat (100) @(negedge clk);
        check_idle1("idle");

        bus1.seg_in = 7'h3F; push_exp(7'h3F, 4'h0, 1'b1, cyc + 19, 0, 0);
        repeat (1000) @(negedge clk);
        bus1.seg_in = 7'h06; push_exp(7'h06, 4'h1, 1'b1, cyc + 19, 0, 1);
        repeat (60) @(negedge clk);

        bus1.seg_in = 7'h7F;
        repeat (10) @(negedge clk);
        bus1.seg_in = 7'h06;
        repeat (60) @(negedge clk);
        check("glitch_fp", 32'(bus1.frame_pattern), 32'h06);
        check("glitch_cnt", 32'(bus1.frame_count), 32'd2);

        bus1.seg_in = 7'h01; push_exp(7'h01, 4'h0, 1'b0, cyc + 19, 0, 1);
        repeat (60) @(negedge clk);
        bus1.seg_in = 7'h7F;
        repeat (5) @(negedge clk);
        bus1.seg_in = 7'h01;
        repeat (60) @(negedge clk);
        check("repeat_cnt", 32'(bus1.frame_count), 32'd3);

        bus1.seg_in = 7'h3F; push_exp(7'h3F, 4'h0, 1'b1, cyc + 19, 0, 1);
        repeat (2500) @(negedge clk);
        bus1.seg_in = 7'h06; push_exp(7'h06, 4'h1, 1'b1, cyc + 19, 0, 1);
        repeat (60) @(negedge clk);
        check("period_2500", 32'(bus1.period), 32'd2500);

        // 20 disabled cycles in mid-filter push the accept and the period count by 20.
        bus1.seg_in = 7'h5B; push_exp(7'h5B, 4'h2, 1'b1, cyc + 39, 20, 1);
        repeat (5) @(negedge clk);
        bus1.ena = 1'b0;
        repeat (20) @(negedge clk);
        bus1.ena = 1'b1;
        repeat (60) @(negedge clk);

        bus1.seg_in = 7'h4F;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle1("midrst");
        check("midrst_sb_empty", 32'(sbq.size()), 32'd0);
        exp_cnt = 0; exp_acc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_exp(7'h4F, 4'h3, 1'b1, cyc + 19, 0, 0);
        repeat (40) @(negedge clk);

        rst2_n = 1'b1;
        bus2.seg_in = 7'h3F; start = cyc;
        wait_fv2("w8_first", start);
        check("w8_ovf_early", 32'(bus2.overflow), 32'h0);
        check("w8_pv_first", 32'(bus2.period_valid), 32'h0);
        repeat (300) @(negedge clk);
        check("w8_ovf_set", 32'(bus2.overflow), 32'h1);
        bus2.seg_in = 7'h06; start = cyc;
        wait_fv2("w8_second", start);
        check("w8_period_sat", 32'(bus2.period), 32'd255);
        check("w8_pv", 32'(bus2.period_valid), 32'h1);
        check("w8_ovf_sticky", 32'(bus2.overflow), 32'h1);
        check("w8_cnt", 32'(bus2.frame_count), 32'd2);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
